// File: rtl/fixed_sat_requant.sv
// Multi-lane saturating requantizer: stage 1 rounds/shifts each signed lane to the
// output fraction width, stage 2 clamps to OUT_W and flags ovf/unf; counters tally events.
module fixed_sat_requant #(
   parameter int IN_W     = 64,
   parameter int IN_FRAC  = 16,
   parameter int OUT_W    = 16,
   parameter int OUT_FRAC = 8,
   parameter int LANES    = 4,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   input  logic                   round_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [LANES-1:0]       out_ovf,
   output logic [LANES-1:0]       out_unf,
   output logic [CNT_W-1:0]       ovf_count,
   output logic [CNT_W-1:0]       unf_count,
   input  logic                   clr_counts
);

   localparam int SH    = IN_FRAC - OUT_FRAC;
   localparam int EXT_W = IN_W + 1;
   localparam int S1W   = EXT_W - SH;
   localparam int PC_W  = $clog2(LANES + 1);
   // Half an output LSB; collapses to zero when no bits are dropped.
   localparam logic [EXT_W-1:0] RND_K   = (EXT_W'(1) << SH) >> 1;
   localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic                   adv;
   logic                   xfer;

   logic                   s1_valid_reg;
   logic [LANES*S1W-1:0]   s1_data_reg;
   logic [LANES*S1W-1:0]   s1_data_next;

   logic                   out_valid_reg;
   logic [LANES*OUT_W-1:0] out_data_reg;
   logic [LANES*OUT_W-1:0] out_data_next;
   logic [LANES-1:0]       out_ovf_reg;
   logic [LANES-1:0]       out_ovf_next;
   logic [LANES-1:0]       out_unf_reg;
   logic [LANES-1:0]       out_unf_next;

   logic [1:0][CNT_W-1:0] cnt_reg;
   logic [1:0][CNT_W-1:0] cnt_next;
   logic [1:0][LANES-1:0] cnt_flags;

   assign adv  = !out_valid_reg || out_ready;
   assign xfer = out_valid_reg && out_ready;

   function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) begin
         c = c + PC_W'(v[i]);
      end
      return c;
   endfunction

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [EXT_W-1:0] ext;
      logic signed [EXT_W-1:0] sum;
      logic [S1W-1:0]          s1_lane;
      logic [S1W-OUT_W:0]      s1_upper;
      logic                    is_ovf;
      logic                    is_unf;

      // One guard bit above the input width keeps the rounding add from wrapping.
      assign ext = $signed({in_data[gi*IN_W+IN_W-1], in_data[gi*IN_W +: IN_W]});
      assign sum = ext + $signed(round_en ? RND_K : '0);
      assign s1_data_next[gi*S1W +: S1W] = S1W'(sum >>> SH);

      // In range only when every bit from the output sign bit upward matches the sign.
      assign s1_lane  = s1_data_reg[gi*S1W +: S1W];
      assign s1_upper = s1_lane[S1W-1:OUT_W-1];
      assign is_ovf   = !s1_lane[S1W-1] && (|s1_upper);
      assign is_unf   = s1_lane[S1W-1] && !(&s1_upper);

      assign out_ovf_next[gi] = is_ovf;
      assign out_unf_next[gi] = is_unf;
      assign out_data_next[gi*OUT_W +: OUT_W] =
         is_ovf ? OUT_MAX : (is_unf ? OUT_MIN : s1_lane[OUT_W-1:0]);
   end

   // Both stages move together; a stalled output freezes the whole pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_data_reg   <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ovf_reg   <= '0;
         out_unf_reg   <= '0;
      end else if (adv) begin
         s1_valid_reg  <= in_valid;
         s1_data_reg   <= s1_data_next;
         out_valid_reg <= s1_valid_reg;
         out_data_reg  <= out_data_next;
         out_ovf_reg   <= out_ovf_next;
         out_unf_reg   <= out_unf_next;
      end
   end

   assign cnt_flags[0] = out_ovf_reg;
   assign cnt_flags[1] = out_unf_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W+PC_W-1:0] cnt_sum;
      logic                  cnt_sat;

      assign cnt_sum = {{PC_W{1'b0}}, cnt_reg[gi]} + {{CNT_W{1'b0}}, popcount(cnt_flags[gi])};
      assign cnt_sat = |cnt_sum[CNT_W+PC_W-1:CNT_W];
      // Clear takes priority over an increment in the same cycle.
      assign cnt_next[gi] = clr_counts ? '0 :
                            (xfer ? (cnt_sat ? '1 : cnt_sum[CNT_W-1:0]) : cnt_reg[gi]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_ovf   = out_ovf_reg;
   assign out_unf   = out_unf_reg;
   assign ovf_count = cnt_reg[0];
   assign unf_count = cnt_reg[1];

endmodule

// File: tb/tb_fixed_sat_requant.sv
// Directed bench for fixed_sat_requant: default instance, a CNT_W=4 twin sharing its
// inputs, and a single-lane SH=0 instance.
module tb_fixed_sat_requant;

   logic         clk;
   logic         rst;
   logic         in_valid, in_ready, round_en, out_valid, out_ready, clr_counts;
   logic [255:0] in_data;
   logic [63:0]  out_data;
   logic [3:0]   out_ovf, out_unf;
   logic [15:0]  ovf_count, unf_count;

   logic         c4_in_ready, c4_out_valid;
   logic [63:0]  c4_out_data;
   logic [3:0]   c4_out_ovf, c4_out_unf, c4_ovf_count, c4_unf_count;

   logic         sw_in_valid, sw_in_ready, sw_round_en, sw_out_valid, sw_out_ready, sw_clr;
   logic [63:0]  sw_in_data;
   logic [15:0]  sw_out_data;
   logic [0:0]   sw_out_ovf, sw_out_unf;
   logic [15:0]  sw_ovf_count, sw_unf_count;

   int checks;
   int errors;

   fixed_sat_requant dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .round_en(round_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .out_unf(out_unf), .ovf_count(ovf_count), .unf_count(unf_count),
      .clr_counts(clr_counts)
   );

   fixed_sat_requant #(.CNT_W(4)) dut_c4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready), .in_data(in_data),
      .round_en(round_en), .out_valid(c4_out_valid), .out_ready(out_ready), .out_data(c4_out_data),
      .out_ovf(c4_out_ovf), .out_unf(c4_out_unf), .ovf_count(c4_ovf_count), .unf_count(c4_unf_count),
      .clr_counts(clr_counts)
   );

   fixed_sat_requant #(.IN_FRAC(8), .OUT_FRAC(8), .LANES(1)) dut_sw (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready), .in_data(sw_in_data),
      .round_en(sw_round_en), .out_valid(sw_out_valid), .out_ready(sw_out_ready),
      .out_data(sw_out_data), .out_ovf(sw_out_ovf), .out_unf(sw_out_unf),
      .ovf_count(sw_ovf_count), .unf_count(sw_unf_count), .clr_counts(sw_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference for one default-parameter lane: Q.16 -> Q8.8, compare-based clamp.
   task automatic model_lane(input logic [63:0] d, input logic r,
                             output logic [15:0] q, output logic o, output logic u);
      logic signed [64:0] e;
      e = $signed({d[63], d});
      if (r) e = e + 65'sd128;
      e = e >>> 8;
      o = 1'b0;
      u = 1'b0;
      if (e > 65'sd32767) begin
         q = 16'h7FFF;
         o = 1'b1;
      end else if (e < -65'sd32768) begin
         q = 16'h8000;
         u = 1'b1;
      end else begin
         q = e[15:0];
      end
   endtask

   task automatic gen_beat(output logic [255:0] d, output logic r);
      logic signed [31:0] t;
      for (int l = 0; l < 4; l++) begin
         if ($urandom_range(0, 7) == 0) begin
            d[l*64 +: 64] = {$urandom, $urandom};
         end else begin
            t = $urandom;
            t = t >>> $urandom_range(0, 14);
            d[l*64 +: 64] = {{32{t[31]}}, t};
         end
      end
      r = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || out_ovf !== 4'h0 || out_unf !== 4'h0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h o=%b u=%b want 0", out_valid, out_data, out_ovf, out_unf);
      end
      checks++;
      if (ovf_count !== 16'h0 || unf_count !== 16'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_counts got ovf=%0d unf=%0d rdy=%b want 0 0 1", ovf_count, unf_count, in_ready);
      end
      #2 rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sw_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b v=%b swv=%b want 1 0 0", in_ready, out_valid, sw_out_valid);
      end
   endtask

   task automatic test_rounding();
      logic [255:0] vec [2];
      logic         rv [2];
      logic [63:0]  exp_d [2];
      vec[0] = {64'hFFFF_FFFF_FFFF_FE80, 64'h0000_0000_0000_017F, 64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0180};
      vec[1] = vec[0];
      rv[0] = 1'b0; exp_d[0] = 64'hFFFE_0001_FFFF_0001;
      rv[1] = 1'b1; exp_d[1] = 64'hFFFF_0001_0000_0002;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = vec[i]; round_en = rv[i];
         step();
         in_valid = 1'b0; in_data = '0; round_en = ~rv[i];
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_early beat %0d got out_valid=%b want 0", i, out_valid);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
            errors++;
            $display("FAIL rnd_data beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d[i]);
         end
         checks++;
         if (out_ovf !== 4'h0 || out_unf !== 4'h0) begin
            errors++;
            $display("FAIL rnd_flags beat %0d got o=%b u=%b want 0000 0000", i, out_ovf, out_unf);
         end
         step();
      end
   endtask

   task automatic test_clamp();
      logic [255:0] vec [2];
      logic         rv [2];
      logic [63:0]  exp_d [2];
      logic [3:0]   exp_o [2];
      logic [3:0]   exp_u [2];
      vec[0] = {64'hFFFF_FFFF_FF7F_FFFF, 64'hFFFF_FFFF_FF80_0000, 64'h0000_0000_0080_0000, 64'h0000_0000_007F_FF00};
      vec[1] = {64'hFFFF_FFFF_FF7F_FF80, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_007F_FF80};
      rv[0] = 1'b0; exp_d[0] = 64'h8000_8000_7FFF_7FFF; exp_o[0] = 4'b0010; exp_u[0] = 4'b1000;
      rv[1] = 1'b1; exp_d[1] = 64'h8000_8000_7FFF_7FFF; exp_o[1] = 4'b0011; exp_u[1] = 4'b0100;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = vec[i]; round_en = rv[i];
         step();
         in_valid = 1'b0; in_data = '0;
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
            errors++;
            $display("FAIL clamp_data beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d[i]);
         end
         checks++;
         if (out_ovf !== exp_o[i] || out_unf !== exp_u[i]) begin
            errors++;
            $display("FAIL clamp_flags beat %0d got o=%b u=%b want o=%b u=%b", i, out_ovf, out_unf, exp_o[i], exp_u[i]);
         end
         step();
      end
   endtask

   task automatic test_counters();
      logic [255:0] pat;
      pat = {64'h0, 64'hFFFF_FFFF_FF7F_FFFF, 64'h0000_0000_0080_0000, 64'h0000_0000_0080_0000};
      out_ready = 1'b1; round_en = 1'b0;
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      checks++;
      if (ovf_count !== 16'd0 || unf_count !== 16'd0) begin
         errors++;
         $display("FAIL cnt_clear_idle got %0d %0d want 0 0", ovf_count, unf_count);
      end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = pat;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready beat %0d got %b want 1", i, in_ready);
         end
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (ovf_count !== 16'd6 || unf_count !== 16'd3) begin
         errors++;
         $display("FAIL cnt_accum got ovf=%0d unf=%0d want 6 3", ovf_count, unf_count);
      end
      checks++;
      if (c4_ovf_count !== 4'd6 || c4_unf_count !== 4'd3) begin
         errors++;
         $display("FAIL cnt4_accum got ovf=%0d unf=%0d want 6 3", c4_ovf_count, c4_unf_count);
      end
      // Clear coinciding with a counted transfer.
      in_valid = 1'b1; in_data = pat;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL clr_xfer_setup got out_valid=%b want 1", out_valid);
      end
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      checks++;
      if (ovf_count !== 16'd0 || unf_count !== 16'd0 || c4_ovf_count !== 4'd0) begin
         errors++;
         $display("FAIL clr_wins got %0d %0d %0d want 0 0 0", ovf_count, unf_count, c4_ovf_count);
      end
      // 20 overflowing lanes: the 4-bit counter pins at 15.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = {4{64'h0000_0000_0080_0000}};
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (ovf_count !== 16'd20 || unf_count !== 16'd0) begin
         errors++;
         $display("FAIL cnt_20 got ovf=%0d unf=%0d want 20 0", ovf_count, unf_count);
      end
      checks++;
      if (c4_ovf_count !== 4'd15) begin
         errors++;
         $display("FAIL cnt4_sat got %0d want 15", c4_ovf_count);
      end
      // A stalled output is not counted until it transfers.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = {4{64'h0000_0000_0080_0000}};
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (ovf_count !== 16'd20 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL cnt_stall got ovf=%0d v=%b rdy=%b want 20 1 0", ovf_count, out_valid, in_ready);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (ovf_count !== 16'd24 || c4_ovf_count !== 4'd15) begin
         errors++;
         $display("FAIL cnt_after_stall got %0d %0d want 24 15", ovf_count, c4_ovf_count);
      end
   endtask

   task automatic test_back_to_back_stream();
      logic [63:0]  exp_q [$];
      logic [3:0]   expo_q [$];
      logic [3:0]   expu_q [$];
      logic [255:0] beat_d;
      logic         beat_r;
      logic [63:0]  ed, held_d;
      logic [3:0]   eo, eu, held_o, held_u;
      logic [15:0]  q;
      logic         o, u, held_valid;
      int           sent, recv, cyc;
      sent = 0; recv = 0; cyc = 0; held_valid = 1'b0;
      held_d = '0; held_o = '0; held_u = '0;
      gen_beat(beat_d, beat_r);
      while ((sent < 20 || recv < 20) && cyc < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid = (sent < 20);
         in_data = beat_d;
         round_en = beat_r;
         #3;
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL stream_ready cyc %0d got %b want %b", cyc, in_ready, !out_valid || out_ready);
         end
         if (held_valid) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_ovf !== held_o || out_unf !== held_u) begin
               errors++;
               $display("FAIL stall_hold cyc %0d got v=%b d=%h want v=1 d=%h", cyc, out_valid, out_data, held_d);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra cyc %0d got d=%h want no output", cyc, out_data);
            end else begin
               ed = exp_q.pop_front();
               eo = expo_q.pop_front();
               eu = expu_q.pop_front();
               if (out_data !== ed || out_ovf !== eo || out_unf !== eu) begin
                  errors++;
                  $display("FAIL stream_data beat %0d got d=%h o=%b u=%b want d=%h o=%b u=%b",
                           recv, out_data, out_ovf, out_unf, ed, eo, eu);
               end
            end
            recv++;
         end
         held_valid = out_valid && !out_ready;
         held_d = out_data; held_o = out_ovf; held_u = out_unf;
         if (in_valid && in_ready) begin
            for (int l = 0; l < 4; l++) begin
               model_lane(beat_d[l*64 +: 64], beat_r, q, o, u);
               ed[l*16 +: 16] = q;
               eo[l] = o;
               eu[l] = u;
            end
            exp_q.push_back(ed);
            expo_q.push_back(eo);
            expu_q.push_back(eu);
            sent++;
            gen_beat(beat_d, beat_r);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (sent != 20 || recv != 20 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL stream_count got sent=%0d recv=%0d left=%0d want 20 20 0", sent, recv, exp_q.size());
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; round_en = 1'b0;
      in_valid = 1'b1; in_data = {4{64'h0000_0000_0080_0000}};
      step();
      in_data = {4{64'h0000_0000_0000_0300}};
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 64'h7FFF_7FFF_7FFF_7FFF) begin
         errors++;
         $display("FAIL ar_inflight got v=%b rdy=%b d=%h want 1 0 7fff7fff7fff7fff", out_valid, in_ready, out_data);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || out_ovf !== 4'h0 || out_unf !== 4'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ar_outputs got v=%b d=%h o=%b u=%b rdy=%b want 0 0 0 0 1",
                  out_valid, out_data, out_ovf, out_unf, in_ready);
      end
      checks++;
      if (ovf_count !== 16'd0 || unf_count !== 16'd0 || c4_ovf_count !== 4'd0) begin
         errors++;
         $display("FAIL ar_counts got %0d %0d %0d want 0 0 0", ovf_count, unf_count, c4_ovf_count);
      end
      #2 rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = {64'h0000_0000_0000_0500, 64'h0, 64'h0, 64'h0000_0000_0012_3400};
      step();
      in_valid = 1'b0; in_data = '0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_stale got out_valid=%b d=%h want 0", out_valid, out_data);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'h0005_0000_0000_1234 || out_ovf !== 4'h0) begin
         errors++;
         $display("FAIL ar_first got v=%b d=%h o=%b want 1 0005000000001234 0000", out_valid, out_data, out_ovf);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_dup got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_param_sweep();
      logic [63:0] vec [5];
      logic        rv [5];
      logic [15:0] exp_d [5];
      logic        exp_o [5];
      logic        exp_u [5];
      vec[0] = 64'h0000_0000_0001_0000; rv[0] = 1'b0; exp_d[0] = 16'h7FFF; exp_o[0] = 1'b1; exp_u[0] = 1'b0;
      vec[1] = 64'h0000_0000_0001_0000; rv[1] = 1'b1; exp_d[1] = 16'h7FFF; exp_o[1] = 1'b1; exp_u[1] = 1'b0;
      vec[2] = 64'hFFFF_FFFF_FFFF_8000; rv[2] = 1'b0; exp_d[2] = 16'h8000; exp_o[2] = 1'b0; exp_u[2] = 1'b0;
      vec[3] = 64'h0000_0000_0000_1234; rv[3] = 1'b1; exp_d[3] = 16'h1234; exp_o[3] = 1'b0; exp_u[3] = 1'b0;
      vec[4] = 64'hFFFF_FFFF_FFFF_7FFF; rv[4] = 1'b0; exp_d[4] = 16'h8000; exp_o[4] = 1'b0; exp_u[4] = 1'b1;
      sw_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sw_in_valid = 1'b1; sw_in_data = vec[i]; sw_round_en = rv[i];
         step();
         sw_in_valid = 1'b0; sw_in_data = '0;
         step();
         checks++;
         if (sw_out_valid !== 1'b1 || sw_out_data !== exp_d[i] ||
             sw_out_ovf[0] !== exp_o[i] || sw_out_unf[0] !== exp_u[i]) begin
            errors++;
            $display("FAIL sweep beat %0d got v=%b d=%h o=%b u=%b want v=1 d=%h o=%b u=%b", i,
                     sw_out_valid, sw_out_data, sw_out_ovf, sw_out_unf, exp_d[i], exp_o[i], exp_u[i]);
         end
         step();
      end
      checks++;
      if (sw_ovf_count !== 16'd2 || sw_unf_count !== 16'd1) begin
         errors++;
         $display("FAIL sweep_counts got %0d %0d want 2 1", sw_ovf_count, sw_unf_count);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; round_en = 1'b0; out_ready = 1'b0; clr_counts = 1'b0;
      sw_in_valid = 1'b0; sw_in_data = '0; sw_round_en = 1'b0; sw_out_ready = 1'b0; sw_clr = 1'b0;
      test_reset();
      test_rounding();
      test_clamp();
      test_counters();
      test_back_to_back_stream();
      test_async_reset();
      test_param_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
